// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage load/store controller.
// Size encodings, FSM states and the alignment rule.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LFIN,
        RMW_RD,
        MERGE,
        WR,
        DONE
    } state_t;

    // Size 2'b11 is handled as a word.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        if (size == SIZE_BYTE) return 1'b0;
        if (size == SIZE_HALF) return off[0];
        return off != 2'b00;
    endfunction

    // Byte and half stores need a read-modify-write.
    function automatic logic is_partial(input logic [1:0] size);
        return size == SIZE_BYTE || size == SIZE_HALF;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle of the MEM-stage unit.
// master = pipeline, slave = mem_access_unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              store;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misaligned;

    modport master (
        output req, store, size, uns, addr, wdata,
        input  busy, done, rdata, misaligned
    );

    modport slave (
        input  req, store, size, uns, addr, wdata,
        output busy, done, rdata, misaligned
    );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane logic: load extract/extend and store lane merge.
// Byte offset 0 is bits [31:24].
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane and extend it to 32 bits
    always_comb begin
        byte_v = 8'h00;
        unique case (off_i)
            2'd0: byte_v = word_i[31:24];
            2'd1: byte_v = word_i[23:16];
            2'd2: byte_v = word_i[15:8];
            2'd3: byte_v = word_i[7:0];
        endcase
        half_v = off_i[1] ? word_i[15:0] : word_i[31:16];
        if (size_i == SIZE_BYTE)
            load_o = {{24{byte_v[7] & ~uns_i}}, byte_v};
        else if (size_i == SIZE_HALF)
            load_o = {{16{half_v[15] & ~uns_i}}, half_v};
        else
            load_o = word_i;
    end

    // Overlay the store byte/half onto the word read back
    always_comb begin
        merged_o = word_i;
        if (size_i == SIZE_BYTE) begin
            unique case (off_i)
                2'd0: merged_o[31:24] = wdata_i[7:0];
                2'd1: merged_o[23:16] = wdata_i[7:0];
                2'd2: merged_o[15:8]  = wdata_i[7:0];
                2'd3: merged_o[7:0]   = wdata_i[7:0];
            endcase
        end else if (size_i == SIZE_HALF) begin
            if (off_i[1]) merged_o[15:0]  = wdata_i[15:0];
            else          merged_o[31:16] = wdata_i[15:0];
        end else begin
            merged_o = wdata_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage load/store controller in front of a word-wide memory.
// Optional alignment trap: define MEM_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_word_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_word_out
);

    state_t            state_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [31:0]       mem_word_in_q;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              mis_req;

    mem_lane_align u_align (
        .size_i   (size_q),
        .uns_i    (uns_q),
        .off_i    (off_q),
        .word_i   (mem_word_out),
        .wdata_i  (wdata_q),
        .load_o   (load_val),
        .merged_o (merged)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;

    assign mis_req = is_misaligned(bus.size, bus.addr[1:0]);

    // Remember whether the accepted request trapped on alignment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mis_q <= 1'b0;
        else if (state_q == IDLE && bus.req)
            mis_q <= mis_req;
    end

    assign bus.misaligned = mis_q && (state_q == DONE);
`else
    assign mis_req        = 1'b0;
    assign bus.misaligned = 1'b0;
`endif

    // Sequencer: accept, memory cycles, lane work, completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            off_q         <= 2'b00;
            wdata_q       <= '0;
            rdata_q       <= '0;
            mem_address_q <= '0;
            mem_word_in_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.req) begin
                    size_q        <= bus.size;
                    uns_q         <= bus.uns;
                    off_q         <= bus.addr[1:0];
                    wdata_q       <= bus.wdata;
                    mem_address_q <= {bus.addr[ADDR_W-1:2], 2'b00};
                    mem_word_in_q <= bus.wdata;
                    if (mis_req)
                        state_q <= DONE;
                    else if (!bus.store)
                        state_q <= RD;
                    else if (is_partial(bus.size))
                        state_q <= RMW_RD;
                    else
                        state_q <= WR;
                end
                RD:     state_q <= LFIN;
                LFIN: begin
                    rdata_q <= load_val;
                    state_q <= DONE;
                end
                RMW_RD: state_q <= MERGE;
                MERGE: begin
                    mem_word_in_q <= merged;
                    state_q       <= WR;
                end
                WR:     state_q <= DONE;
                DONE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read    = (state_q == RD) || (state_q == RMW_RD);
    assign mem_write   = (state_q == WR);
    assign mem_address = mem_address_q;
    assign mem_word_in = mem_word_in_q;
    assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
    assign bus.done    = (state_q == DONE);
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a big-endian word memory.
// Works with or without MEM_ALIGN_CHECK_EN.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_word_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_word_out;
    logic [31:0] mem [0:255];
    int          checks;
    int          errors;
    int          both_cnt;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_address  (mem_address),
        .mem_word_in  (mem_word_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_word_out (mem_word_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output memory, one-cycle read latency
    always @(posedge clk) begin
        if (mem_read) mem_word_out <= mem[mem_address[9:2]];
        if (mem_write) mem[mem_address[9:2]] <= mem_word_in;
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic issue(
        input  logic        st,
        input  logic [1:0]  sz,
        input  logic        u,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output int          lat,
        output int          rd_cyc,
        output int          wr_cyc,
        output logic        busy1
    );
        @(negedge clk);
        bus.req = 1'b1; bus.store = st; bus.size = sz;
        bus.uns = u; bus.addr = a; bus.wdata = wd;
        @(negedge clk);
        bus.req = 1'b0;
        lat = -1; rd_cyc = -1; wr_cyc = -1; busy1 = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) busy1 = bus.busy;
            if (mem_read && rd_cyc < 0) rd_cyc = i;
            if (mem_write && wr_cyc < 0) wr_cyc = i;
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req = 1'b0; bus.store = 1'b0; bus.size = 2'b00;
        bus.uns = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.misaligned, mem_read, mem_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 00000",
                {bus.busy, bus.done, bus.misaligned, mem_read, mem_write});
        end
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h exp 0", bus.rdata);
        end
        checks++;
        if (mem_address !== 32'h0 || mem_word_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got %h/%h exp 0/0", mem_address, mem_word_in);
        end
    endtask

    task automatic test_sw;
        int lat, rc, wc; logic b1;
        issue(1'b1, 2'b10, 1'b0, 32'd400, 32'hDEADBEEF, lat, rc, wc, b1);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL sw_lat got %0d exp 2", lat); end
        checks++;
        if (wc !== 1 || rc !== -1) begin
            errors++; $display("FAIL sw_cyc got wr %0d rd %0d exp 1 -1", wc, rc);
        end
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL sw_busy got %b exp 1", b1); end
        checks++;
        if (mem_address !== 32'd400) begin
            errors++; $display("FAIL sw_addr got %0d exp 400", mem_address);
        end
        checks++;
        if (mem[100] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_mem got %h exp deadbeef", mem[100]);
        end
    endtask

    task automatic test_loads;
        logic [1:0]  sz [8];
        logic        un [8];
        logic [31:0] ad [8];
        logic [31:0] ex [8];
        int lat, rc, wc; logic b1;
        sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
        un = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ad = '{32'd401, 32'd401, 32'd402, 32'd400,
               32'd403, 32'd400, 32'd400, 32'd400};
        ex = '{32'hFFFFFFAD, 32'h000000AD, 32'h0000BEEF, 32'hFFFFDEAD,
               32'hFFFFFFEF, 32'h000000DE, 32'hDEADBEEF, 32'hDEADBEEF};
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rc, wc, b1);
            checks++;
            if (bus.rdata !== ex[i]) begin
                errors++;
                $display("FAIL load%0d_data got %h exp %h", i, bus.rdata, ex[i]);
            end
            checks++;
            if (lat !== 3 || rc !== 1 || wc !== -1) begin
                errors++;
                $display("FAIL load%0d_timing got lat %0d rd %0d wr %0d exp 3 1 -1",
                    i, lat, rc, wc);
            end
        end
    endtask

    task automatic test_sub_store;
        int lat, rc, wc; logic b1;
        issue(1'b1, 2'b00, 1'b0, 32'd402, 32'h00000011, lat, rc, wc, b1);
        checks++;
        if (lat !== 4 || rc !== 1 || wc !== 3) begin
            errors++;
            $display("FAIL sb_timing got lat %0d rd %0d wr %0d exp 4 1 3", lat, rc, wc);
        end
        checks++;
        if (mem[100] !== 32'hDEAD11EF) begin
            errors++; $display("FAIL sb_mem got %h exp dead11ef", mem[100]);
        end
        issue(1'b1, 2'b01, 1'b1, 32'd400, 32'hABCD5678, lat, rc, wc, b1);
        checks++;
        if (lat !== 4 || mem[100] !== 32'h567811EF) begin
            errors++;
            $display("FAIL sh_mem got lat %0d word %h exp 4 567811ef", lat, mem[100]);
        end
        issue(1'b0, 2'b10, 1'b0, 32'd400, 32'h0, lat, rc, wc, b1);
        checks++;
        if (bus.rdata !== 32'h567811EF) begin
            errors++; $display("FAIL sh_readback got %h exp 567811ef", bus.rdata);
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL rd_wr_overlap got %0d exp 0", both_cnt);
        end
    endtask

    task automatic test_rdata_hold;
        int lat, rc, wc; logic b1;
        issue(1'b1, 2'b00, 1'b0, 32'd408, 32'h0000007F, lat, rc, wc, b1);
        checks++;
        if (bus.rdata !== 32'h567811EF) begin
            errors++; $display("FAIL rdata_hold got %h exp 567811ef", bus.rdata);
        end
    endtask

    task automatic test_reset_mid;
        int lat, rc, wc; logic b1;
        issue(1'b1, 2'b10, 1'b0, 32'd404, 32'h01020304, lat, rc, wc, b1);
        @(negedge clk);
        bus.req = 1'b1; bus.store = 1'b1; bus.size = 2'b00;
        bus.addr = 32'd404; bus.wdata = 32'h000000AA;
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (mem_read !== 1'b1) begin
            errors++; $display("FAIL rmw_rd_entry got %b exp 1", mem_read);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw got rd %b busy %b exp 0 0", mem_read, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.store = 1'b1; bus.size = 2'b10;
        bus.addr = 32'd404; bus.wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++; $display("FAIL wr_entry got %b exp 1", mem_write);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr got wr %b busy %b exp 0 0", mem_write, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'd404, 32'h0, lat, rc, wc, b1);
        checks++;
        if (lat !== 3 || bus.rdata !== 32'h01020304) begin
            errors++;
            $display("FAIL after_rst got lat %0d data %h exp 3 01020304", lat, bus.rdata);
        end
    endtask

    task automatic test_misaligned;
        int lat, rc, wc; logic b1;
        issue(1'b0, 2'b10, 1'b0, 32'd401, 32'h0, lat, rc, wc, b1);
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (lat !== 1 || rc !== -1 || bus.misaligned !== 1'b1) begin
            errors++;
            $display("FAIL lw_mis got lat %0d rd %0d mis %b exp 1 -1 1",
                lat, rc, bus.misaligned);
        end
        checks++;
        if (bus.rdata !== 32'h01020304) begin
            errors++; $display("FAIL lw_mis_rdata got %h exp 01020304", bus.rdata);
        end
        issue(1'b0, 2'b01, 1'b0, 32'd403, 32'h0, lat, rc, wc, b1);
        checks++;
        if (lat !== 1 || bus.misaligned !== 1'b1) begin
            errors++;
            $display("FAIL lh_mis got lat %0d mis %b exp 1 1", lat, bus.misaligned);
        end
`else
        checks++;
        if (lat !== 3 || rc !== 1 || bus.misaligned !== 1'b0) begin
            errors++;
            $display("FAIL lw_401 got lat %0d rd %0d mis %b exp 3 1 0",
                lat, rc, bus.misaligned);
        end
        checks++;
        if (bus.rdata !== 32'h567811EF || mem_address !== 32'd400) begin
            errors++;
            $display("FAIL lw_401_data got %h @%0d exp 567811ef @400",
                bus.rdata, mem_address);
        end
        issue(1'b0, 2'b01, 1'b0, 32'd403, 32'h0, lat, rc, wc, b1);
        checks++;
        if (bus.rdata !== 32'h000011EF) begin
            errors++; $display("FAIL lh_403 got %h exp 000011ef", bus.rdata);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int lat, rc, wc; logic b1;
        issue(1'b1, 2'b10, 1'b0, 32'd412, 32'h00000080, lat, rc, wc, b1);
        issue(1'b0, 2'b00, 1'b0, 32'd415, 32'h0, lat, rc, wc, b1);
        checks++;
        if (lat !== 3 || bus.rdata !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL b2b_lb got lat %0d data %h exp 3 ffffff80", lat, bus.rdata);
        end
        issue(1'b0, 2'b00, 1'b1, 32'd412, 32'h0, lat, rc, wc, b1);
        checks++;
        if (lat !== 3 || bus.rdata !== 32'h00000000) begin
            errors++;
            $display("FAIL b2b_lbu got lat %0d data %h exp 3 0", lat, bus.rdata);
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL overlap_final got %0d exp 0", both_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        both_cnt = 0;
        test_reset();
        test_sw();
        test_loads();
        test_sub_store();
        test_rdata_hold();
        test_reset_mid();
        test_misaligned();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
